move_unpacker: RTL and testbench

MOVE_UNPACKER -- requirements
Module: move_unpacker

---
 rtl/move_unpacker.sv | 176 +++++++++++++++++
 tb/tb_move_unpacker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_unpacker.sv
// move_unpacker
// Drains one square's move FIFO. Each FIFO word carries SLOTS 19-bit move
// slots under 8 fill bits. Words are read one at a time. The slots of a word
// are presented on a valid/ready port from the highest index down to 0, and
// slots marked invalid are dropped.
//
// Ports
//   clk        single clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle pulse that begins draining the FIFO (honoured only
//              in IDLE or DONE)
//   fifoIn     FIFO q word: [SLOTS*19+7 -: 8] fill, slot i at [i*19 +: 19]
//   fifoEmpty  FIFO empty flag
//   rden       FIFO read request, asserted only in READ
//   mvOut      current move; IMOV (19'h40000) whenever mvValid is low
//   mvValid    mvOut holds a valid move
//   mvReady    consumer accepts mvOut
//   moveCount  moves accepted since the last start, saturating at 255
//   busy       high in every state except IDLE and DONE
//   done       high while in DONE
module move_unpacker #(
  parameter int SLOTS = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SLOTS*19+7:0]   fifoIn,
  input  logic                  fifoEmpty,
  output logic                  rden,
  output logic [18:0]           mvOut,
  output logic                  mvValid,
  input  logic                  mvReady,
  output logic [7:0]            moveCount,
  output logic                  busy,
  output logic                  done
);

  localparam int MV_W      = 19;
  localparam int SLOT_BITS = SLOTS * MV_W;
  localparam int IDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [MV_W-1:0]  IMOV     = 19'h40000;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [7:0]       CNT_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WAIT,
    SCAN,
    DONE
  } state_t;

  state_t                 state_reg, state_next;
  logic [SLOT_BITS-1:0]   slots_reg, slots_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [7:0]             count_reg, count_next;

  logic [MV_W-1:0]        slot_word [SLOTS];
  logic [MV_W-1:0]        cur_slot;
  logic                   cur_valid;
  logic                   advance;

  // The fill byte carries no move data and is dropped on purpose.
  logic                   unused_fill;
  assign unused_fill = ^fifoIn[SLOT_BITS +: 8];

  // View the captured word as an array of slots.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign slot_word[gi] = slots_reg[gi*MV_W +: MV_W];
    end
  endgenerate

  assign cur_slot  = slot_word[idx_reg];
  assign cur_valid = ~cur_slot[MV_W-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      slots_reg <= {SLOTS{IMOV}};
      idx_reg   <= LAST_IDX;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      slots_reg <= slots_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  // The outputs are decoded directly from the state. An asynchronous reset
  // therefore takes them to their idle values at once, without waiting for
  // a clock edge.
  always_comb begin
    state_next = state_reg;
    slots_next = slots_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    rden       = 1'b0;
    mvValid    = 1'b0;
    mvOut      = IMOV;
    busy       = 1'b1;
    done       = 1'b0;
    advance    = 1'b0;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          count_next = '0;
          state_next = CHECK;
        end
      end

      CHECK: begin
        state_next = fifoEmpty ? DONE : READ;
      end

      READ: begin
        rden       = 1'b1;
        state_next = WAIT;
      end

      // The FIFO is non-show-ahead, so its q output becomes valid one cycle
      // after rden. That data is captured at the end of this cycle.
      WAIT: begin
        slots_next = fifoIn[SLOT_BITS-1:0];
        idx_next   = LAST_IDX;
        state_next = SCAN;
      end

      SCAN: begin
        if (cur_valid) begin
          mvValid = 1'b1;
          mvOut   = cur_slot;
          advance = mvReady;
          if (mvReady && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 8'd1;
          end
        end else begin
          advance = 1'b1;
        end

        // The next word is requested only after the last slot of the
        // current word has gone.
        if (advance) begin
          if (idx_reg == '0) begin
            state_next = CHECK;
          end else begin
            idx_next = idx_reg - IDX_W'(1);
          end
        end
      end

      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) begin
          count_next = '0;
          state_next = CHECK;
        end
      end

      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign moveCount = count_reg;

endmodule

// File: tb/tb_move_unpacker.sv
// Self-checking bench for move_unpacker.
// A small non-show-ahead FIFO model feeds the DUT. Each stimulus task pushes
// the moves it expects into exp_q. A monitor running on the falling edge pops
// exp_q and compares it on every mvValid/mvReady handshake. Directed checks
// cover timing, backpressure, reset and saturation.
module tb_move_unpacker;

  localparam logic [18:0] IMOV = 19'h40000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [159:0] fifoIn = '0;
  logic         fifoEmpty;
  logic         rden;
  logic [18:0]  mvOut;
  logic         mvValid;
  logic         mvReady;
  logic [7:0]   moveCount;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rden_cnt = 0;
  int hs_total = 0;
  int hs_cyc_log [512];

  logic [159:0] fifo_mem [128];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic [18:0]  exp_q [$];

  always #5 clk = ~clk;

  assign fifoEmpty = (rd_ptr == wr_ptr);

  move_unpacker #(.SLOTS(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .fifoIn    (fifoIn),
    .fifoEmpty (fifoEmpty),
    .rden      (rden),
    .mvOut     (mvOut),
    .mvValid   (mvValid),
    .mvReady   (mvReady),
    .moveCount (moveCount),
    .busy      (busy),
    .done      (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: q updates on the edge that samples rden.
  always @(posedge clk) begin
    if (rden && (rd_ptr < wr_ptr)) begin
      fifoIn <= fifo_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    logic [18:0] exp_mv;
    forever begin
      @(negedge clk);
      if (rden) begin
        rden_cnt++;
        chk("rden_while_empty", fifoEmpty, 1'b0);
      end
      if (mvValid && mvReady) begin
        hs_cyc_log[hs_total] = cyc;
        hs_total++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_move got=%05h want=none (cycle %0d)", mvOut, cyc);
        end else begin
          exp_mv = exp_q.pop_front();
          chk("move", mvOut, exp_mv);
          $display("move %05h accepted at cycle %0d", mvOut, cyc);
        end
      end else if (!mvValid) begin
        chk("idle_mvout", mvOut, IMOV);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int c0);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      tick();
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (mvValid) begin
        at = cyc;
        break;
      end
      tick();
    end
    chk("valid_reached", mvValid, 1'b1);
  endtask

  task automatic push_exp(input logic [159:0] w);
    for (int s = 7; s >= 0; s--) begin
      if (!w[s*19 + 18]) exp_q.push_back(w[s*19 +: 19]);
    end
  endtask

  task automatic load(input logic [159:0] w, input bit expect_now);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
    if (expect_now) push_exp(w);
  endtask

  function automatic logic [159:0] full_word(input logic [7:0] seed);
    logic [159:0] w;
    w = '0;
    w[159:152] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      w[i*19 +: 19] = {1'b0, 2'b01, seed, 5'd0, 3'(i)};
    end
    return w;
  endfunction

  initial begin
    int c0, at, r0, hs0;
    logic [159:0] w, a_word, b_word;

    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, at, r0, hs0;
    logic [159:0] w, a_word, b_word;

    reset_n = 1'b0;
    start   = 1'b0;
    mvReady = 1'b1;
    tick(); tick(); tick();
    chk("rst_rden", rden, 1'b0);
    chk("rst_mvvalid", mvValid, 1'b0);
    chk("rst_mvout", mvOut, IMOV);
    chk("rst_movecount", moveCount, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    reset_n = 1'b1;
    tick();

    // Empty FIFO: DONE two cycles after start, no read.
    r0 = rden_cnt;
    pulse_start(c0);
    chk("empty_busy_in_check", busy, 1'b1);
    wait_done(20, at);
    chk("empty_done_cycle", at, c0 + 2);
    chk("empty_movecount", moveCount, 8'd0);
    chk("empty_rden_count", rden_cnt - r0, 0);
    $display("empty fifo: done at cycle %0d", at);

    // One word: only slots 7 and 2 are valid. Fill bits are set to junk.
    w = {8'hFF, 19'h12345, {4{19'h7FFFF}}, 19'h3ABCD, {2{19'h7FFFF}}};
    load(w, 1'b0);
    exp_q.push_back(19'h12345);
    exp_q.push_back(19'h3ABCD);
    hs0 = hs_total;
    r0  = rden_cnt;
    pulse_start(c0);
    wait_done(40, at);
    chk("sparse_hs_count", hs_total - hs0, 2);
    chk("sparse_slot7_cycle", hs_cyc_log[hs0], c0 + 4);
    chk("sparse_slot2_cycle", hs_cyc_log[hs0 + 1], c0 + 9);
    chk("sparse_done_cycle", at, c0 + 13);
    chk("sparse_rden_count", rden_cnt - r0, 1);
    chk("sparse_movecount", moveCount, 8'd2);
    chk("sparse_sb_empty", exp_q.size(), 0);

    // Backpressure on slot 7 for five cycles.
    mvReady = 1'b0;
    w = {8'h00, 19'h00ABC, 19'h12222, {6{19'h5FFFF}}};
    load(w, 1'b1);
    pulse_start(c0);
    wait_valid(10, at);
    chk("bp_first_valid_cycle", at, c0 + 4);
    r0 = rden_cnt;
    for (int k = 0; k < 5; k++) begin
      chk("bp_mvvalid_hold", mvValid, 1'b1);
      chk("bp_mvout_hold", mvOut, 19'h00ABC);
      tick();
    end
    chk("bp_no_rden", rden_cnt - r0, 0);
    chk("bp_movecount_frozen", moveCount, 8'd0);
    mvReady = 1'b1;
    wait_done(40, at);
    chk("bp_movecount", moveCount, 8'd2);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Two full words.
    load(full_word(8'd1), 1'b1);
    load(full_word(8'd2), 1'b1);
    r0  = rden_cnt;
    hs0 = hs_total;
    pulse_start(c0);
    wait_done(100, at);
    chk("two_rden_count", rden_cnt - r0, 2);
    chk("two_hs_count", hs_total - hs0, 16);
    chk("two_movecount", moveCount, 8'd16);
    chk("two_sb_empty", exp_q.size(), 0);

    // Reset in the middle of the SCAN of word A. Word B follows A in the FIFO.
    a_word = full_word(8'd3);
    b_word = full_word(8'd4);
    b_word[6*19 + 18] = 1'b1;
    b_word[3*19 + 18] = 1'b1;
    b_word[0*19 + 18] = 1'b1;
    load(a_word, 1'b0);
    load(b_word, 1'b0);
    exp_q.push_back(a_word[151:133]);
    mvReady = 1'b0;
    pulse_start(c0);
    wait_valid(10, at);
    mvReady = 1'b1;
    tick();
    chk("mid_movecount_before_rst", moveCount, 8'd1);
    mvReady = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rden", rden, 1'b0);
    chk("mid_rst_mvvalid", mvValid, 1'b0);
    chk("mid_rst_mvout", mvOut, IMOV);
    chk("mid_rst_movecount", moveCount, 8'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    r0 = rden_cnt;
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("mid_no_rden_after_rst", rden_cnt - r0, 0);
    chk("mid_idle_after_rst", busy, 1'b0);
    mvReady = 1'b1;
    push_exp(b_word);
    pulse_start(c0);
    wait_done(60, at);
    chk("mid_restart_rden_count", rden_cnt - r0, 1);
    chk("mid_restart_movecount", moveCount, 8'd5);
    chk("mid_sb_empty", exp_q.size(), 0);

    // Saturation: 32 full words give 256 moves, and the count holds at 255.
    for (int k = 0; k < 32; k++) load(full_word(8'(k + 16)), 1'b1);
    hs0 = hs_total;
    pulse_start(c0);
    wait_done(1000, at);
    chk("sat_hs_count", hs_total - hs0, 256);
    chk("sat_movecount", moveCount, 8'd255);
    chk("sat_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
